aes_uart_ctrl: RTL

Frame controller that sequences the UART byte transceiver (`uart_rx_tx`) against the AES-128 encryption core. It assembles received UART bytes into command frames, loads the key or launches an encryption, and streams the 16-byte ciphertext or a one-byte acknowledge back through the UART transmitter. It sits between `uart_rx_tx` and the AES core in the encryption top level and is the only block that drives `uart_tx_start` and the AES start strobe.

---
 rtl/aes_uart_pkg.sv | 19 +
 rtl/aes_uart_tx_seq.sv | 78 +++++++
 rtl/aes_uart_ctrl.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/aes_uart_pkg.sv
// Shared types and constants for the UART-to-AES frame controller.
package aes_uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RX_PAYLOAD,
        AES_START,
        AES_WAIT,
        TX_LOAD,
        TX_WAIT_BUSY,
        TX_WAIT_DONE
    } ctrl_state_t;

    localparam logic [7:0] CMD_KEY_DEFAULT = 8'h4B;
    localparam logic [7:0] CMD_ENC_DEFAULT = 8'h45;
    localparam logic [7:0] RSP_ERR         = 8'h3F;
    localparam int         FRAME_BYTES     = 16;

endpackage

// File: rtl/aes_uart_tx_seq.sv
// Transmit sequencer: streams 1 or 16 bytes MSB-first through the UART
// transmitter using the start / ready-low / ready-high handshake.
module aes_uart_tx_seq
    import aes_uart_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [127:0] load_data,
    input  logic         load_single,
    input  logic         tx_ready,
    output logic [7:0]   tx_data,
    output logic         tx_start,
    output logic         busy
);

    ctrl_state_t  phase_q, phase_d;
    logic [127:0] shift_q, shift_d;
    logic [4:0]   cnt_q, cnt_d;
    logic [7:0]   data_q, data_d;
    logic         start_q, start_d;

    always_comb begin
        phase_d = phase_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        start_d = 1'b0;
        case (phase_q)
            IDLE: begin
                if (load) begin
                    shift_d = load_data;
                    cnt_d   = load_single ? 5'd1 : 5'(FRAME_BYTES);
                    phase_d = TX_LOAD;
                end
            end
            TX_LOAD: begin
                if (tx_ready) begin
                    data_d  = shift_q[127:120];
                    start_d = 1'b1;
                    phase_d = TX_WAIT_BUSY;
                end
            end
            TX_WAIT_BUSY: begin
                if (!tx_ready) phase_d = TX_WAIT_DONE;
            end
            TX_WAIT_DONE: begin
                if (tx_ready) begin
                    shift_d = shift_q << 8;
                    cnt_d   = cnt_q - 5'd1;
                    phase_d = (cnt_q == 5'd1) ? IDLE : TX_LOAD;
                end
            end
            default: phase_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            start_q <= 1'b0;
        end else begin
            phase_q <= phase_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            start_q <= start_d;
        end
    end

    assign tx_data  = data_q;
    assign tx_start = start_q;
    assign busy     = (phase_q != IDLE);

endmodule

// File: rtl/aes_uart_ctrl.sv
// Frame controller: assembles UART command frames, loads the AES key or runs
// an encryption, and returns the ciphertext or a one-byte response.
module aes_uart_ctrl
    import aes_uart_pkg::*;
#(
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd100000,
    parameter logic [7:0]  CMD_KEY        = CMD_KEY_DEFAULT,
    parameter logic [7:0]  CMD_ENC        = CMD_ENC_DEFAULT
) (
    input  logic         uart_clock,
    input  logic         uart_reset,
    input  logic [7:0]   uart_received_data,
    input  logic         uart_rx_valid,
    input  logic         uart_tx_ready,
    output logic [7:0]   uart_transmit_data,
    output logic         uart_tx_start,
    output logic [127:0] aes_key,
    output logic [127:0] aes_plaintext,
    output logic         aes_start,
    input  logic [127:0] aes_ciphertext,
    input  logic         aes_done,
    output logic         ctrl_busy,
    output logic         ctrl_error
);

    ctrl_state_t  state_q, state_d;
    logic         rx_prev_q, rx_prev_d;
    logic         evt_q, evt_d;
    logic [7:0]   byte_q, byte_d;
    logic [7:0]   cmd_q, cmd_d;
    logic [127:0] asm_q, asm_d;
    logic [3:0]   cnt_q, cnt_d;
    logic [23:0]  timer_q, timer_d;
    logic [127:0] key_q, key_d;
    logic [127:0] pt_q, pt_d;
    logic         start_q, start_d;
    logic         busy_q, busy_d;
    logic         err_q, err_d;
    logic         tx_load, tx_single, tx_busy;
    logic [127:0] tx_load_data;

    always_comb begin
        rx_prev_d    = uart_rx_valid;
        evt_d        = uart_rx_valid & ~rx_prev_q;
        byte_d       = uart_received_data;
        state_d      = state_q;
        cmd_d        = cmd_q;
        asm_d        = asm_q;
        cnt_d        = cnt_q;
        key_d        = key_q;
        pt_d         = pt_q;
        err_d        = err_q;
        start_d      = 1'b0;
        tx_load      = 1'b0;
        tx_single    = 1'b1;
        tx_load_data = '0;
        // Timer only runs while a frame is partially received; any byte restarts it.
        timer_d      = (state_q == RX_PAYLOAD && !evt_q) ? timer_q + 24'd1 : 24'd0;

        case (state_q)
            IDLE: begin
                if (evt_q) begin
                    cmd_d = byte_q;
                    if (byte_q == CMD_KEY || byte_q == CMD_ENC) begin
                        cnt_d   = 4'd0;
                        state_d = RX_PAYLOAD;
                    end else begin
                        err_d        = 1'b1;
                        tx_load      = 1'b1;
                        tx_load_data = {RSP_ERR, 120'h0};
                        state_d      = TX_LOAD;
                    end
                end
            end
            RX_PAYLOAD: begin
                if (evt_q) begin
                    asm_d = {asm_q[119:0], byte_q};
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == 4'd15) begin
                        if (cmd_q == CMD_KEY) begin
                            key_d        = asm_d;
                            tx_load      = 1'b1;
                            tx_load_data = {CMD_KEY, 120'h0};
                            state_d      = TX_LOAD;
                        end else begin
                            pt_d    = asm_d;
                            state_d = AES_START;
                        end
                    end
                end else if (timer_q >= TIMEOUT_CYCLES) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            AES_START: begin
                start_d = 1'b1;
                state_d = AES_WAIT;
            end
            AES_WAIT: begin
                if (aes_done) begin
                    tx_load      = 1'b1;
                    tx_single    = 1'b0;
                    tx_load_data = aes_ciphertext;
                    state_d      = TX_LOAD;
                end
            end
            // The sequencer owns the byte handshake; wait here until it drains.
            default: begin
                if (!tx_busy) state_d = IDLE;
            end
        endcase

        if (evt_q && state_q != IDLE && state_q != RX_PAYLOAD) err_d = 1'b1;
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge uart_clock or negedge uart_reset) begin
        if (!uart_reset) begin
            state_q   <= IDLE;
            rx_prev_q <= 1'b1;
            evt_q     <= 1'b0;
            byte_q    <= '0;
            cmd_q     <= '0;
            asm_q     <= '0;
            cnt_q     <= '0;
            timer_q   <= '0;
            key_q     <= '0;
            pt_q      <= '0;
            start_q   <= 1'b0;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            rx_prev_q <= rx_prev_d;
            evt_q     <= evt_d;
            byte_q    <= byte_d;
            cmd_q     <= cmd_d;
            asm_q     <= asm_d;
            cnt_q     <= cnt_d;
            timer_q   <= timer_d;
            key_q     <= key_d;
            pt_q      <= pt_d;
            start_q   <= start_d;
            busy_q    <= busy_d;
            err_q     <= err_d;
        end
    end

    aes_uart_tx_seq u_tx_seq (
        .clk         (uart_clock),
        .rst_n       (uart_reset),
        .load        (tx_load),
        .load_data   (tx_load_data),
        .load_single (tx_single),
        .tx_ready    (uart_tx_ready),
        .tx_data     (uart_transmit_data),
        .tx_start    (uart_tx_start),
        .busy        (tx_busy)
    );

    assign aes_key       = key_q;
    assign aes_plaintext = pt_q;
    assign aes_start     = start_q;
    assign ctrl_busy     = busy_q;
    assign ctrl_error    = err_q;

endmodule
